// File: rtl/buzzer_pkg.sv
//==============================================================================
// buzzer_pkg : shared state encoding, LMAX helper and 50 MHz default timings
// Revision   : 1.0
//==============================================================================
`default_nettype none

package buzzer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SOUND   = 3'd1,
    HOLD    = 3'd2,
    DECAY   = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  localparam int unsigned DEF_MIN_ON_CYC     = 2_500_000;   // 50 ms
  localparam int unsigned DEF_MAX_ON_CYC     = 100_000_000; // 2 s
  localparam int unsigned DEF_DECAY_STEP_CYC = 800_000;     // 16 ms
  localparam int unsigned DEF_PWM_BITS       = 4;

  function automatic int unsigned lmax(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_level_gate.sv
//==============================================================================
// pwm_level_gate : volume gate (PWM vs level) and registered buzzer pin
// Revision       : 1.0   (PWM counter present only with BUZZER_DECAY_EN)
//==============================================================================
`default_nettype none

module pwm_level_gate
  import buzzer_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] level,
  input  logic                tone_in,
  output logic                buzzer
);

  localparam logic [PWM_BITS-1:0] c_lmax = PWM_BITS'(lmax(PWM_BITS));

  logic w_gate;
  logic buzzer_d, buzzer_q;

`ifdef BUZZER_DECAY_EN
  logic [PWM_BITS-1:0] pwm_cnt_d, pwm_cnt_q;

  // Full level bypasses the PWM so an undamped note is a clean square wave.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    w_gate    = (level == c_lmax) || (pwm_cnt_q < level);
    buzzer_d  = tone_in & w_gate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      buzzer_q  <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      buzzer_q  <= buzzer_d;
    end
  end
`else
  always_comb begin
    w_gate   = (level == c_lmax);
    buzzer_d = tone_in & w_gate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzzer_q <= 1'b0;
    end else begin
      buzzer_q <= buzzer_d;
    end
  end
`endif

  assign buzzer = buzzer_q;

endmodule

`default_nettype wire

// File: rtl/buzzer_gate.sv
//==============================================================================
// buzzer_gate : buzzer output stage - minimum note, lockout, optional fade
// Revision    : 1.0   (fade-out enabled by defining BUZZER_DECAY_EN)
//==============================================================================
`default_nettype none

module buzzer_gate
  import buzzer_pkg::*;
#(
  parameter int unsigned MIN_ON_CYC     = DEF_MIN_ON_CYC,
  parameter int unsigned MAX_ON_CYC     = DEF_MAX_ON_CYC,
  parameter int unsigned DECAY_STEP_CYC = DEF_DECAY_STEP_CYC,
  parameter int unsigned PWM_BITS       = DEF_PWM_BITS
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic tone_in,
  input  logic key_active,
  output logic buzzer,
  output logic busy,
  output logic timeout_flag
);

  localparam int unsigned         c_on_w    = (MAX_ON_CYC > 1) ? $clog2(MAX_ON_CYC) : 1;
  localparam logic [c_on_w-1:0]   c_on_last = c_on_w'(MAX_ON_CYC - 1);
  localparam logic [c_on_w-1:0]   c_on_min  = c_on_w'(MIN_ON_CYC - 1);
  localparam logic [PWM_BITS-1:0] c_lmax    = PWM_BITS'(lmax(PWM_BITS));

  // Illegal timing combinations leave this block empty; kept to document limits.
  if (MIN_ON_CYC < 1 || MAX_ON_CYC <= MIN_ON_CYC || DECAY_STEP_CYC < 1) begin : g_param_limits
  end

`ifdef BUZZER_DECAY_EN
  localparam state_e c_release_st = DECAY;
`else
  localparam state_e c_release_st = IDLE;
`endif

  state_e              state_d, state_q;
  logic [c_on_w-1:0]   on_cnt_d, on_cnt_q;
  logic                timeout_d, timeout_q;
  logic [c_on_w-1:0]   w_on_inc;
  logic [PWM_BITS-1:0] w_level;

`ifdef BUZZER_DECAY_EN
  localparam int unsigned       c_step_w    = (DECAY_STEP_CYC > 1) ? $clog2(DECAY_STEP_CYC) : 1;
  localparam logic [c_step_w-1:0] c_step_last = c_step_w'(DECAY_STEP_CYC - 1);

  logic [c_step_w-1:0] step_cnt_d, step_cnt_q;
  logic [PWM_BITS-1:0] level_d, level_q;
  logic                w_last_step;

  assign w_last_step = (step_cnt_q == c_step_last);
`endif

  assign w_on_inc = (&on_cnt_q) ? on_cnt_q : on_cnt_q + c_on_w'(1);

  always_comb begin
    state_d   = state_q;
    on_cnt_d  = on_cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (key_active) begin
          state_d   = SOUND;
          on_cnt_d  = '0;
          timeout_d = 1'b0;
        end
      end
      SOUND: begin
        on_cnt_d = w_on_inc;
        if (key_active && (on_cnt_q == c_on_last)) begin
          state_d   = LOCKOUT;
          timeout_d = 1'b1;
        end else if (!key_active) begin
          state_d = (on_cnt_q >= c_on_min) ? c_release_st : HOLD;
        end
      end
      HOLD: begin
        on_cnt_d = w_on_inc;
        if (key_active) begin
          state_d = SOUND;
        end else if (on_cnt_q == c_on_min) begin
          state_d = c_release_st;
        end
      end
`ifdef BUZZER_DECAY_EN
      DECAY: begin
        // A new press wins even over the step that would end the fade.
        if (key_active) begin
          state_d   = SOUND;
          on_cnt_d  = '0;
          timeout_d = 1'b0;
        end else if (w_last_step && (level_q == PWM_BITS'(1))) begin
          state_d = IDLE;
        end
      end
`endif
      LOCKOUT: begin
        if (!key_active) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BUZZER_DECAY_EN
  always_comb begin
    level_d    = level_q;
    step_cnt_d = step_cnt_q;
    if ((state_d == SOUND) && (state_q != SOUND) && (state_q != HOLD)) begin
      level_d = c_lmax;
    end else if (state_d == LOCKOUT) begin
      level_d = '0;
    end else if (state_q == DECAY) begin
      if (w_last_step) begin
        step_cnt_d = '0;
        level_d    = level_q - PWM_BITS'(1);
      end else begin
        step_cnt_d = step_cnt_q + c_step_w'(1);
      end
    end
    if ((state_d == DECAY) && (state_q != DECAY)) begin
      step_cnt_d = '0;
    end
  end

  assign w_level = level_q;
`else
  assign w_level = ((state_q == SOUND) || (state_q == HOLD)) ? c_lmax : '0;
`endif

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      on_cnt_q   <= '0;
      timeout_q  <= 1'b0;
`ifdef BUZZER_DECAY_EN
      step_cnt_q <= '0;
      level_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      on_cnt_q   <= on_cnt_d;
      timeout_q  <= timeout_d;
`ifdef BUZZER_DECAY_EN
      step_cnt_q <= step_cnt_d;
      level_q    <= level_d;
`endif
    end
  end

  pwm_level_gate #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_level_gate (
    .clk     (clk_50MHz),
    .rst_n   (reset),
    .level   (w_level),
    .tone_in (tone_in),
    .buzzer  (buzzer)
  );

  assign busy         = (state_q != IDLE);
  assign timeout_flag = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_buzzer_gate.sv
//==============================================================================
// tb_buzzer_gate : randomized bench for buzzer_gate with note-level reference
// Revision       : 1.0   (model follows BUZZER_DECAY_EN like the design)
//==============================================================================
`default_nettype none

module tb_buzzer_gate;

  localparam int MIN_ON  = 8;
  localparam int MAX_ON  = 64;
  localparam int DSTEP   = 4;
  localparam int PB      = 2;
  localparam int LMAXV   = 3;
`ifdef BUZZER_DECAY_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic clk        = 1'b0;
  logic reset      = 1'b1;
  logic tone_in    = 1'b0;
  logic key_active = 1'b0;
  logic buzzer, busy, timeout_flag;

  always #10 clk = ~clk;

  buzzer_gate #(
    .MIN_ON_CYC     (MIN_ON),
    .MAX_ON_CYC     (MAX_ON),
    .DECAY_STEP_CYC (DSTEP),
    .PWM_BITS       (PB)
  ) dut (
    .clk_50MHz    (clk),
    .reset        (reset),
    .tone_in      (tone_in),
    .key_active   (key_active),
    .buzzer       (buzzer),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Note-level reference: a note is "on" from press until release after the
  // minimum length; a fade lasts LMAX*DSTEP cycles; lockout after MAX_ON.
  int m_phase;    // 0 silent, 1 note, 2 fading, 3 locked out
  int m_age;      // cycles since the note started
  int m_fade;     // cycles since the fade started
  int m_pwm;      // cycles since reset, modulo 2^PB
  bit m_flag;
  bit m_buz;

  function automatic int m_level();
    if (m_phase == 1) return LMAXV;
    if (m_phase == 2) return LMAXV - (m_fade / DSTEP);
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    int lvl;
    bit gate;
    if (!reset) begin
      m_phase = 0; m_age = 0; m_fade = 0; m_pwm = 0; m_flag = 0; m_buz = 0;
    end else begin
      lvl   = m_level();
      gate  = FADE ? ((lvl == LMAXV) || (m_pwm < lvl)) : (lvl == LMAXV);
      m_buz = tone_in && gate;
      m_pwm = (m_pwm + 1) % (1 << PB);
      case (m_phase)
        0: if (key_active) begin m_phase = 1; m_age = 0; m_flag = 0; end
        1: begin
          if (key_active && m_age == MAX_ON - 1) begin
            m_phase = 3; m_flag = 1;
          end else if (!key_active && m_age >= MIN_ON - 1) begin
            m_phase = FADE ? 2 : 0; m_fade = 0;
          end else begin
            m_age++;
          end
        end
        2: begin
          if (key_active) begin
            m_phase = 1; m_age = 0; m_flag = 0;
          end else begin
            m_fade++;
            if (m_fade == LMAXV * DSTEP) m_phase = 0;
          end
        end
        default: if (!key_active) m_phase = 0;
      endcase
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("buzzer", buzzer, m_buz);
      check("busy", busy, m_phase != 0);
      check("timeout_flag", timeout_flag, m_flag);
    end
  end

  initial begin
    int nb, hb, nsound, len;
    bit k;

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_buzzer", buzzer, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_flag, 0);
    reset  = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Short tap with constant tone: minimum length then (optional) fade.
    tone_in = 1'b1; key_active = 1'b1; nb = 0; hb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (buzzer) hb++;
      if (i == 1) key_active = 1'b0;
    end
    check("tap_busy_cycles", nb, FADE ? 20 : 8);
    check("tap_buzzer_highs", hb, FADE ? 15 : 8);

    // Long hold with toggling tone: lockout after MAX_ON cycles of sound.
    key_active = 1'b1; nsound = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) tone_in = ~tone_in;
      @(negedge clk);
      if (busy && !timeout_flag) nsound++;
    end
    check("hold_sound_cycles", nsound, 64);
    check("hold_locked_flag", timeout_flag, 1);
    key_active = 1'b0;
    @(negedge clk);
    check("lock_release_busy", busy, 0);
    check("lock_release_flag", timeout_flag, 1);
    repeat (3) @(negedge clk);

    // Restrike five cycles into the release phase.
    tone_in = 1'b1; key_active = 1'b1;
    repeat (2) @(negedge clk);
    check("restrike_flag_cleared", timeout_flag, 0);
    repeat (18) @(negedge clk);
    key_active = 1'b0;
    repeat (5) @(negedge clk);
    key_active = 1'b1;
    @(negedge clk);
    check("restrike_busy", busy, 1);
    repeat (4) @(negedge clk);
    key_active = 1'b0;
    repeat (30) @(negedge clk);

    // Asynchronous reset in the middle of a note.
    key_active = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_buzzer", buzzer, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_buzzer", buzzer, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_timeout", timeout_flag, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_sound", busy, 1);
    key_active = 1'b0;
    repeat (30) @(negedge clk);

    // Randomized key runs and tone, long runs occasionally reach lockout.
    for (int n = 0; n < 3000; n += len) begin
      k   = ($urandom % 2) == 1;
      len = k ? int'($urandom_range(1, 90)) : int'($urandom_range(1, 30));
      key_active = k;
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 2) == 0) tone_in = ~tone_in;
        @(negedge clk);
      end
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
